grf_trace: RTL and testbench
============================

Name: grf_trace

Overview:
- Parametrised general register file for the pipelined CPU.
- N combinational read ports with write-to-read bypass; one write port; register 0 hardwired to zero.
- Every committed write is pushed into an internal trace FIFO, drained by the testbench/debug unit over a valid/ready handshake. This replaces simulation-only print statements with synthesizable trace.
- Sits in the decode stage (reads) and the writeback stage (write).

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (>=1).
- PC_W, 32, width of the PC tag carried with each write.
- TRACE_DEPTH, 4, trace FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- WriteEnable  in  1  write request this cycle.
- WriteAddress  in  ADDR_W  destination register.
- WriteData  in  DATA_W  data to write.
- WritePC  in  PC_W  PC of the writing instruction (trace tag only).
- ReadAddress  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- ReadData  out  NUM_RD*DATA_W  packed read data, same packing.
- TraceValid  out  1  FIFO head entry valid.
- TraceReady  in  1  consumer accepts the head entry.
- TraceAddress  out  ADDR_W  head entry register number.
- TraceData  out  DATA_W  head entry data.
- TracePC  out  PC_W  head entry PC.
- TraceFull  out  1  FIFO holds TRACE_DEPTH entries.
- TraceOverflow  out  1  sticky flag: a trace entry was dropped.

Behaviour:
- Clock and reset: one clock, clk; Reset is synchronous and active-high.
- Commit condition: commit = WriteEnable && WriteAddress != 0 && !Reset. On the rising edge, register[WriteAddress] <= WriteData.
- Register 0: never written; always reads 0.
- Reads are combinational, zero latency, per port k:
  - ReadAddress_k == 0 -> 0.
  - else if commit && WriteAddress == ReadAddress_k -> WriteData (write-first bypass).
  - else register[ReadAddress_k].
- While Reset is high the bypass is disabled and reads return array contents.
- Reset edge:
  - All registers <= 0; FIFO emptied (pointers and count 0).
  - TraceOverflow <= 0.
  - Reset wins over a simultaneous WriteEnable: nothing committed, nothing traced.
- Reset values of outputs: TraceValid 0, TraceFull 0, TraceOverflow 0, TraceAddress/TraceData/TracePC 0. ReadData reflects zeroed array.
- Trace push: every commit pushes {WritePC, WriteAddress, WriteData}. Writes to register 0 and non-committed cycles push nothing.
- Trace pop: fires when TraceValid && TraceReady.
- FIFO is show-ahead: TraceValid = (count != 0); TraceAddress/Data/PC show the head entry combinationally from storage.
- While TraceValid is low, trace outputs hold 0.
- Latency: a commit at edge N makes the entry visible at the head (if FIFO was empty) after edge N, i.e. in cycle N+1.
- Push while full with no pop:
  - The register write still commits (the file is never stalled).
  - The entry is dropped; TraceOverflow <= 1 and stays set until Reset.
- Push and pop in the same cycle, full: pop frees the head, push accepted. Count unchanged, no overflow.
- Push and pop in the same cycle, empty: push only (TraceValid was 0); count becomes 1.
- TraceFull = (count == TRACE_DEPTH), combinational from count.
- Pointers are ADDR-of-FIFO wide and wrap modulo TRACE_DEPTH. Count is clog2(TRACE_DEPTH)+1 bits.
- TraceReady with TraceValid low is ignored.

Decomposition:
- Shared package grf_pkg holds:
  - REG_ZERO constant (0); default DATA_W/ADDR_W/PC_W constants.
  - packed typedef trace_entry_t {pc, addr, data} used by the FIFO and debug consumers.
- One sub-module, grf_trace_fifo: parametrised show-ahead synchronous FIFO with push/pop, full, count, and drop-on-full overflow flag.
- The register array, read mux and bypass stay in grf_trace.

Test Plan:
- Reset, then NUM_RD=2 reads of addresses 0..31 -> all ReadData 0; TraceValid 0; TraceOverflow 0.
- Write addr 5 = 0xDEADBEEF, PC 0x3000, while ReadAddress port0=5 in the same cycle -> port0 = 0xDEADBEEF that cycle (bypass). Next cycle port0 still 0xDEADBEEF; trace head = {0x3000, 5, 0xDEADBEEF}, TraceValid 1.
- Write addr 0 = 0x12345678 -> port read of 0 returns 0 in that cycle and after; no trace entry pushed.
- TraceReady held 0; 5 writes to regs 1..5 with TRACE_DEPTH=4:
  - TraceFull 1 after the 4th write; 5th write commits (reg5 reads back) and TraceOverflow 1.
  - Draining yields regs 1,2,3,4 in order.
- FIFO full, TraceReady 1 and a new write to reg 7 in the same cycle -> count stays 4, TraceOverflow unchanged, reg 7 entry appears last in the drain order.
- Reset asserted together with WriteEnable to reg 3 = 0xFF -> reg 3 reads 0 afterwards, FIFO empty, TraceOverflow cleared.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants and trace record layout for the general register file
// and any debug logic that consumes its write trace.
package grf_pkg;

   localparam int unsigned REG_ZERO       = 0;
   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam int unsigned DEFAULT_ADDR_W = 5;
   localparam int unsigned DEFAULT_PC_W   = 32;

   typedef struct packed {
      logic [DEFAULT_PC_W-1:0]   pc;
      logic [DEFAULT_ADDR_W-1:0] addr;
      logic [DEFAULT_DATA_W-1:0] data;
   } trace_entry_t;

endpackage

// File: rtl/grf_trace_fifo.sv
// Show-ahead synchronous FIFO for write-trace records; a push into a full
// FIFO with no simultaneous pop is dropped and latches a sticky overflow flag.
module grf_trace_fifo
   import grf_pkg::*;
#(
   parameter int WIDTH = 69,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         pushData,
   input  logic                     pop,
   output logic [WIDTH-1:0]         headData,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic             notEmpty;
   logic             popFire;
   logic             pushAccept;

   assign notEmpty   = (count != '0);
   assign full       = (count == CNT_W'(DEPTH));
   assign popFire    = pop && notEmpty;
   // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
   assign pushAccept = push && (!full || popFire);
   assign headData   = notEmpty ? mem[rdPtr] : '0;

   always_ff @(posedge clk) begin
      if (pushAccept) begin
         mem[wrPtr] <= pushData;
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         rdPtr    <= '0;
         wrPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pushAccept) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (popFire) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushAccept, popFire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !pushAccept) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/grf_trace.sv
// General register file with combinational write-first read ports, a
// hardwired zero register, and a synthesizable trace of every committed write.
module grf_trace
   import grf_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int NUM_RD      = 2,
   parameter int PC_W        = 32,
   parameter int TRACE_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     WriteEnable,
   input  logic [ADDR_W-1:0]        WriteAddress,
   input  logic [DATA_W-1:0]        WriteData,
   input  logic [PC_W-1:0]          WritePC,
   input  logic [NUM_RD*ADDR_W-1:0] ReadAddress,
   output logic [NUM_RD*DATA_W-1:0] ReadData,
   output logic                     TraceValid,
   input  logic                     TraceReady,
   output logic [ADDR_W-1:0]        TraceAddress,
   output logic [DATA_W-1:0]        TraceData,
   output logic [PC_W-1:0]          TracePC,
   output logic                     TraceFull,
   output logic                     TraceOverflow
);

   localparam int ENTRY_W = PC_W + ADDR_W + DATA_W;
   localparam int CNT_W   = $clog2(TRACE_DEPTH) + 1;

   logic [DATA_W-1:0]  regs [2**ADDR_W];
   logic               commit;
   logic [ENTRY_W-1:0] headEntry;
   logic [CNT_W-1:0]   traceCount;

   // Reset masks the write entirely, so it also disables the read bypass.
   assign commit = WriteEnable && (WriteAddress != ADDR_W'(REG_ZERO)) && !Reset;

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int i = 0; i < 2**ADDR_W; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         regs[WriteAddress] <= WriteData;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : gRead
      logic [ADDR_W-1:0] readAddr;
      assign readAddr = ReadAddress[k*ADDR_W +: ADDR_W];
      assign ReadData[k*DATA_W +: DATA_W] =
         (readAddr == ADDR_W'(REG_ZERO))            ? '0 :
         (commit && (WriteAddress == readAddr))     ? WriteData :
                                                      regs[readAddr];
   end

   grf_trace_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (TRACE_DEPTH)
   ) uFifo (
      .clk      (clk),
      .Reset    (Reset),
      .push     (commit),
      .pushData ({WritePC, WriteAddress, WriteData}),
      .pop      (TraceReady),
      .headData (headEntry),
      .full     (TraceFull),
      .count    (traceCount),
      .overflow (TraceOverflow)
   );

   assign TraceValid = (traceCount != '0);
   assign {TracePC, TraceAddress, TraceData} = headEntry;

endmodule

// File: tb/tb_grf_trace.sv
// Directed self-checking bench for grf_trace: bypass reads, zero register,
// trace FIFO ordering, full/overflow behaviour and reset-over-write priority.
module tb_grf_trace;
   import grf_pkg::*;

   logic        clk = 1'b0;
   logic        Reset;
   logic        WriteEnable;
   logic [4:0]  WriteAddress;
   logic [31:0] WriteData;
   logic [31:0] WritePC;
   logic [9:0]  ReadAddress;
   logic [63:0] ReadData;
   logic        TraceValid;
   logic        TraceReady;
   logic [4:0]  TraceAddress;
   logic [31:0] TraceData;
   logic [31:0] TracePC;
   logic        TraceFull;
   logic        TraceOverflow;

   int checks   = 0;
   int failures = 0;

   trace_entry_t drainQ [4];

   always #5 clk = ~clk;

   grf_trace #(
      .DATA_W      (32),
      .ADDR_W      (5),
      .NUM_RD      (2),
      .PC_W        (32),
      .TRACE_DEPTH (4)
   ) dut (
      .clk           (clk),
      .Reset         (Reset),
      .WriteEnable   (WriteEnable),
      .WriteAddress  (WriteAddress),
      .WriteData     (WriteData),
      .WritePC       (WritePC),
      .ReadAddress   (ReadAddress),
      .ReadData      (ReadData),
      .TraceValid    (TraceValid),
      .TraceReady    (TraceReady),
      .TraceAddress  (TraceAddress),
      .TraceData     (TraceData),
      .TracePC       (TracePC),
      .TraceFull     (TraceFull),
      .TraceOverflow (TraceOverflow)
   );

   // Inputs change on the falling edge; checks follow 1ns later, before the next rising edge.
   task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] pc,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic ready);
      @(negedge clk);
      Reset        = rst;
      WriteEnable  = we;
      WriteAddress = wa;
      WriteData    = wd;
      WritePC      = pc;
      ReadAddress  = {ra1, ra0};
      TraceReady   = ready;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkHead(input string tag, input logic [31:0] pc,
                            input logic [4:0] addr, input logic [31:0] data);
      checkOutput({tag, "_valid"}, 64'(TraceValid), 64'd1);
      checkOutput({tag, "_pc"},    64'(TracePC),    64'(pc));
      checkOutput({tag, "_addr"},  64'(TraceAddress), 64'(addr));
      checkOutput({tag, "_data"},  64'(TraceData),  64'(data));
   endtask

   initial begin
      Reset = 1'b1; WriteEnable = 1'b0; WriteAddress = '0; WriteData = '0;
      WritePC = '0; ReadAddress = '0; TraceReady = 1'b0;
      repeat (3) @(negedge clk);
      Reset = 1'b0;

      // After reset every register reads zero on both ports.
      for (int a = 0; a < 32; a++) begin
         ReadAddress = {5'(31 - a), 5'(a)};
         #1;
         checkOutput("reset_rd0", 64'(ReadData[31:0]), 64'd0);
         checkOutput("reset_rd1", 64'(ReadData[63:32]), 64'd0);
      end
      checkOutput("reset_valid", 64'(TraceValid), 64'd0);
      checkOutput("reset_full", 64'(TraceFull), 64'd0);
      checkOutput("reset_ovf", 64'(TraceOverflow), 64'd0);
      checkOutput("reset_taddr", 64'(TraceAddress), 64'd0);
      checkOutput("reset_tdata", 64'(TraceData), 64'd0);
      checkOutput("reset_tpc", 64'(TracePC), 64'd0);

      // Write-first bypass, then trace head one cycle later.
      applyStimulus(0, 1, 5, 32'hDEADBEEF, 32'h3000, 5, 6, 0);
      checkOutput("bypass_rd0", 64'(ReadData[31:0]), 64'hDEADBEEF);
      checkOutput("bypass_rd1", 64'(ReadData[63:32]), 64'd0);
      checkOutput("bypass_valid", 64'(TraceValid), 64'd0);
      applyStimulus(0, 0, 0, 0, 0, 5, 6, 1);
      checkOutput("stored_rd0", 64'(ReadData[31:0]), 64'hDEADBEEF);
      checkHead("head_r5", 32'h3000, 5, 32'hDEADBEEF);
      applyStimulus(0, 0, 0, 0, 0, 5, 6, 0);
      checkOutput("popped_valid", 64'(TraceValid), 64'd0);
      checkOutput("popped_tdata", 64'(TraceData), 64'd0);

      // Register 0 ignores writes and pushes no trace.
      applyStimulus(0, 1, 0, 32'h12345678, 32'h3100, 0, 5, 0);
      checkOutput("r0_same_cycle", 64'(ReadData[31:0]), 64'd0);
      checkOutput("r0_rd1_r5", 64'(ReadData[63:32]), 64'hDEADBEEF);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("r0_after", 64'(ReadData[31:0]), 64'd0);
      checkOutput("r0_no_trace", 64'(TraceValid), 64'd0);

      // Fill the FIFO with four writes; the fifth commits but is dropped.
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 1, 5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i), 5'(i), 0, 0);
         checkOutput("fill_bypass", 64'(ReadData[31:0]), 64'(32'h100 + 32'(i)));
         checkOutput("fill_full", 64'(TraceFull), 64'(i == 5));
         checkOutput("fill_ovf", 64'(TraceOverflow), 64'd0);
      end
      applyStimulus(0, 0, 0, 0, 0, 5, 1, 0);
      checkOutput("r5_readback", 64'(ReadData[31:0]), 64'h105);
      checkOutput("r1_readback", 64'(ReadData[63:32]), 64'h101);
      checkOutput("full_after4", 64'(TraceFull), 64'd1);
      checkOutput("ovf_set", 64'(TraceOverflow), 64'd1);
      checkHead("head_r1", 32'h4004, 1, 32'h101);

      // Full FIFO with simultaneous pop and push: entry for reg 7 joins the tail.
      applyStimulus(0, 1, 7, 32'h777, 32'h5000, 7, 0, 1);
      checkOutput("pp_bypass", 64'(ReadData[31:0]), 64'h777);
      checkHead("pp_head_r1", 32'h4004, 1, 32'h101);
      drainQ[0] = '{pc: 32'h4008, addr: 5'd2, data: 32'h102};
      drainQ[1] = '{pc: 32'h400C, addr: 5'd3, data: 32'h103};
      drainQ[2] = '{pc: 32'h4010, addr: 5'd4, data: 32'h104};
      drainQ[3] = '{pc: 32'h5000, addr: 5'd7, data: 32'h777};
      for (int j = 0; j < 4; j++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
         checkHead("drain", drainQ[j].pc, drainQ[j].addr, drainQ[j].data);
         checkOutput("drain_full", 64'(TraceFull), 64'(j == 0));
         checkOutput("drain_ovf", 64'(TraceOverflow), 64'd1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("drained_valid", 64'(TraceValid), 64'd0);
      checkOutput("drained_full", 64'(TraceFull), 64'd0);

      // Reset beats a simultaneous write; bypass is off while Reset is high.
      applyStimulus(1, 1, 3, 32'hFF, 32'h6000, 3, 7, 0);
      checkOutput("rst_nobypass", 64'(ReadData[31:0]), 64'h103);
      checkOutput("rst_rd_r7", 64'(ReadData[63:32]), 64'h777);
      applyStimulus(0, 0, 0, 0, 0, 3, 7, 0);
      checkOutput("rst_r3", 64'(ReadData[31:0]), 64'd0);
      checkOutput("rst_r7", 64'(ReadData[63:32]), 64'd0);
      checkOutput("rst_valid", 64'(TraceValid), 64'd0);
      checkOutput("rst_ovf", 64'(TraceOverflow), 64'd0);
      checkOutput("rst_full", 64'(TraceFull), 64'd0);

      // Refill (first push coincides with TraceReady on an empty FIFO), then push+pop while full.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 5'(8 + i), 32'hA0 + 32'(i), 32'h7000 + 32'(4 * i), 0, 0, i == 0);
      end
      applyStimulus(0, 1, 12, 32'hAC, 32'h7100, 8, 12, 1);
      checkOutput("refill_full", 64'(TraceFull), 64'd1);
      checkOutput("refill_rd_r8", 64'(ReadData[31:0]), 64'hA0);
      checkOutput("refill_bypass", 64'(ReadData[63:32]), 64'hAC);
      checkHead("refill_head_r8", 32'h7000, 8, 32'hA0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("pp_full_keep", 64'(TraceFull), 64'd1);
      checkOutput("pp_no_ovf", 64'(TraceOverflow), 64'd0);
      checkHead("pp_head_r9", 32'h7004, 9, 32'hA1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
